// File: rtl/if_stage_pkg.sv
// Shared defines for the MIPS fetch front end: enable levels, bus types, NOP word and fetch states.
package if_stage_pkg;

    localparam logic RstEnable   = 1'b1;
    localparam logic RstDisable  = 1'b0;
    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    typedef logic [31:0] inst_addr_bus_t;
    typedef logic [31:0] inst_bus_t;

    // IDLE keeps the ROM disabled; FETCH streams instructions until the next reset.
    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register with stall, bubble and start-up priority (reset > hold > bubble > idle > load).
import if_stage_pkg::*;

module if_id_reg (
    input  logic           clk,
    input  logic           rst,
    input  logic           stall_if_i,
    input  logic           stall_id_i,
    input  logic           ce_i,
    input  inst_addr_bus_t pc_i,
    input  inst_bus_t      inst_i,
    output inst_addr_bus_t id_pc_o,
    output inst_bus_t      id_inst_o
);

    inst_addr_bus_t id_pc_q, id_pc_d;
    inst_bus_t      id_inst_q, id_inst_d;

    always_comb begin
        id_pc_d   = id_pc_q;
        id_inst_d = id_inst_q;
        if (stall_id_i) begin
            id_pc_d   = id_pc_q;
            id_inst_d = id_inst_q;
        end else if (stall_if_i || ce_i == ChipDisable) begin
            id_pc_d   = ZeroWord;
            id_inst_d = NOP_INST;
        end else begin
            id_pc_d   = pc_i;
            id_inst_d = inst_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            id_pc_q   <= ZeroWord;
            id_inst_q <= NOP_INST;
        end else begin
            id_pc_q   <= id_pc_d;
            id_inst_q <= id_inst_d;
        end
    end

    assign id_pc_o   = id_pc_q;
    assign id_inst_o = id_inst_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC counter, ROM request and IF/ID register.
// Optional IF_STAGE_FETCH_CNT_EN adds fetch_cnt_o, counting real instructions handed to decode.
import if_stage_pkg::*;

module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           stall_if_i,
    input  logic           stall_id_i,
    output logic           rom_ce_o,
    output inst_addr_bus_t rom_addr_o,
    input  inst_bus_t      rom_data_i,
    output inst_addr_bus_t id_pc_o,
`ifdef IF_STAGE_FETCH_CNT_EN
    output inst_bus_t      id_inst_o,
    output logic [31:0]    fetch_cnt_o
`else
    output inst_bus_t      id_inst_o
`endif
);

    fetch_state_e   state_q, state_d;
    inst_addr_bus_t pc_q, pc_d;

    // PC is pinned to RESET_PC while the ROM is disabled, so FETCH always starts there.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (state_q == IDLE) begin
            state_d = FETCH;
            pc_d    = RESET_PC;
        end else if (!stall_if_i) begin
            pc_d = pc_q + 32'(PC_STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign rom_ce_o   = (state_q == FETCH) ? ChipEnable : ChipDisable;
    assign rom_addr_o = pc_q;

    if_id_reg u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .stall_if_i (stall_if_i),
        .stall_id_i (stall_id_i),
        .ce_i       (rom_ce_o),
        .pc_i       (pc_q),
        .inst_i     (rom_data_i),
        .id_pc_o    (id_pc_o),
        .id_inst_o  (id_inst_o)
    );

`ifdef IF_STAGE_FETCH_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;

    // Only a genuine ROM-to-decode transfer counts; bubbles, holds and IDLE do not.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        if (!stall_id_i && !stall_if_i && rom_ce_o == ChipEnable) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            fetch_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
`endif

endmodule
